// File: rtl/mac_param_engine.sv
// Multiply-accumulate engine: N_TERMS operand pairs in, registered sum of products out with a done pulse.
// Optional MAC_SAT_EN makes every accumulate step saturate instead of wrapping.
module mac_param_engine #(
  parameter int DATA_W  = 4,
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  input  logic              i_signed_mode,
  input  logic [DATA_W-1:0] i_a_in,
  input  logic [DATA_W-1:0] i_b_in,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [ACC_W-1:0]  o_out,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_ovf
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(N_TERMS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  logic               r_mode;
  logic               r_p_vld;
  logic               r_sticky;
  logic [PW-1:0]      r_p;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic [ACC_W-1:0]   r_out;
  logic               r_done;
  logic               r_busy;
  logic               r_ovf;

  logic [PW-1:0]      w_a_ext;
  logic [PW-1:0]      w_b_ext;
  logic [PW-1:0]      w_prod;
  logic [ACC_W-1:0]   w_p_ext;
  logic [ACC_W:0]     w_sum;
  logic               w_sovf;
  logic               w_wrap;
  logic               w_acc_ovf;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_accept;
  logic               w_last;

  // Operands extended to full product width so one multiplier serves both modes.
  assign w_a_ext = r_mode ? {{DATA_W{i_a_in[DATA_W-1]}}, i_a_in} : {{DATA_W{1'b0}}, i_a_in};
  assign w_b_ext = r_mode ? {{DATA_W{i_b_in[DATA_W-1]}}, i_b_in} : {{DATA_W{1'b0}}, i_b_in};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_p_ext   = r_mode ? ACC_W'($signed(r_p)) : ACC_W'(r_p);
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_p_ext};
  assign w_sovf    = (r_acc[ACC_W-1] == w_p_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_wrap    = r_mode ? w_sovf : w_sum[ACC_W];
  assign w_acc_ovf = r_p_vld && w_wrap;

`ifdef MAC_SAT_EN
  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_wrap) begin
      if (!r_mode)
        w_acc_next = '1;
      else if (r_acc[ACC_W-1])
        w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else
        w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
    if (!r_p_vld)
      w_acc_next = r_acc;
  end
`else
  assign w_acc_next = r_p_vld ? w_sum[ACC_W-1:0] : r_acc;
`endif

  assign w_accept = r_in_ready && i_in_valid;
  assign w_last   = (r_cnt == CNT_W'(N_TERMS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_p_vld    <= 1'b0;
      r_sticky   <= 1'b0;
      r_p        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_out      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_p_vld <= 1'b0;
      r_acc   <= w_acc_next;
      if (w_acc_ovf)
        r_sticky <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_state    <= S_RUN;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
            r_mode     <= i_signed_mode;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_p     <= w_prod;
            r_p_vld <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Final product is folded in here so out carries the complete sum.
          r_out   <= w_acc_next;
          r_ovf   <= r_sticky | w_acc_ovf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_out      = r_out;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_mac_param_engine.sv
// Directed bench for mac_param_engine: default build, ACC_W=8 overflow build and N_TERMS=1 build.
module tb_mac_param_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       smode;
  logic       vld;
  logic [3:0] a;
  logic [3:0] b;
  logic       go0, go8, go1;

  logic        rdy0, done0, busy0, ovf0;
  logic [11:0] out0;
  logic        rdy8, done8, busy8, ovf8;
  logic [7:0]  out8;
  logic        rdy1, done1, busy1, ovf1;
  logic [11:0] out1;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic        rdy_m, done_m, busy_m, ovf_m;
  logic [11:0] out_m;

  mac_param_engine #(.DATA_W(4), .N_TERMS(8), .ACC_W(12)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_go(go0), .i_signed_mode(smode),
    .i_a_in(a), .i_b_in(b), .i_in_valid(vld), .o_in_ready(rdy0),
    .o_out(out0), .o_done(done0), .o_busy(busy0), .o_ovf(ovf0));

  mac_param_engine #(.DATA_W(4), .N_TERMS(8), .ACC_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_go(go8), .i_signed_mode(smode),
    .i_a_in(a), .i_b_in(b), .i_in_valid(vld), .o_in_ready(rdy8),
    .o_out(out8), .o_done(done8), .o_busy(busy8), .o_ovf(ovf8));

  mac_param_engine #(.DATA_W(4), .N_TERMS(1), .ACC_W(12)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_go(go1), .i_signed_mode(smode),
    .i_a_in(a), .i_b_in(b), .i_in_valid(vld), .o_in_ready(rdy1),
    .o_out(out1), .o_done(done1), .o_busy(busy1), .o_ovf(ovf1));

  always_comb begin
    rdy_m = rdy0; done_m = done0; busy_m = busy0; ovf_m = ovf0; out_m = out0;
    case (sel)
      1: begin rdy_m = rdy8; done_m = done8; busy_m = busy8; ovf_m = ovf8; out_m = {4'b0, out8}; end
      2: begin rdy_m = rdy1; done_m = done1; busy_m = busy1; ovf_m = ovf1; out_m = out1; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_go(input int s, input logic v);
    go0 = (s == 0) ? v : 1'b0;
    go8 = (s == 1) ? v : 1'b0;
    go1 = (s == 2) ? v : 1'b0;
  endtask

  task automatic start_go(input int s, input logic sm);
    smode = sm;
    set_go(s, 1'b1);
    tick();
    set_go(s, 1'b0);
  endtask

  // pat 0 holds valid high; pat 1 asserts valid every third cycle. go_at injects a go mid-run.
  task automatic feed(input int n, input logic [3:0] av, input logic [3:0] bv,
                      input int pat, input int go_at);
    int   got;
    int   cyc;
    logic take;
    got = 0;
    cyc = 0;
    a = av;
    b = bv;
    while (got < n && cyc < 100) begin
      vld = (pat == 0) || (cyc % 3 == 0);
      if (cyc == go_at) set_go(sel, 1'b1);
      take = vld && rdy_m;
      tick();
      set_go(sel, 1'b0);
      if (take) got++;
      cyc++;
    end
    vld = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL feed_accepts: accepted %0d, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out0 !== 12'd0) begin errors++; $display("FAIL reset_out: got %0d, want 0", out0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, want 0", rdy0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, want 0", ovf0); end
    checks++; if (out8 !== 8'd0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_other: out8 %0d busy1 %b, want 0 0", out8, busy1);
    end
  endtask

  task automatic test_unsigned();
    sel = 0;
    start_go(0, 1'b0);
    checks++; if (busy_m !== 1'b1 || rdy_m !== 1'b1) begin
      errors++; $display("FAIL uns_after_go: busy %b ready %b, want 1 1", busy_m, rdy_m);
    end
    feed(8, 4'd15, 4'd15, 0, -1);
    checks++; if (done_m !== 1'b0 || rdy_m !== 1'b0 || busy_m !== 1'b1) begin
      errors++; $display("FAIL uns_drain: done %b ready %b busy %b, want 0 0 1", done_m, rdy_m, busy_m);
    end
    tick();
    checks++; if (done_m !== 1'b1) begin errors++; $display("FAIL uns_done: got %b, want 1", done_m); end
    checks++; if (out_m !== 12'h708) begin errors++; $display("FAIL uns_out: got %h, want 708", out_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL uns_ovf: got %b, want 0", ovf_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL uns_busy_done: got %b, want 0", busy_m); end
    tick();
    checks++; if (done_m !== 1'b0 || out_m !== 12'h708) begin
      errors++; $display("FAIL uns_hold: done %b out %h, want 0 708", done_m, out_m);
    end
  endtask

  task automatic test_signed();
    sel = 0;
    start_go(0, 1'b1);
    smode = 1'b0;
    feed(8, 4'h8, 4'h7, 0, -1);
    tick();
    checks++; if (done_m !== 1'b1) begin errors++; $display("FAIL sgn_done: got %b, want 1", done_m); end
    checks++; if (out_m !== 12'hE40) begin errors++; $display("FAIL sgn_out: got %h, want e40", out_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL sgn_ovf: got %b, want 0", ovf_m); end
  endtask

  task automatic test_back_pressure();
    sel = 0;
    tick();
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL bp_idle_ready: got %b, want 0", rdy_m); end
    start_go(0, 1'b0);
    feed(8, 4'd3, 4'd5, 1, 4);
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL bp_drain_ready: got %b, want 0", rdy_m); end
    tick();
    checks++; if (out_m !== 12'd120 || done_m !== 1'b1) begin
      errors++; $display("FAIL bp_out: out %0d done %b, want 120 1", out_m, done_m);
    end
    tick();
    checks++; if (busy_m !== 1'b0 || rdy_m !== 1'b0) begin
      errors++; $display("FAIL bp_go_ignored: busy %b ready %b, want 0 0", busy_m, rdy_m);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] exp_out;
`ifdef MAC_SAT_EN
    exp_out = 12'd255;
`else
    exp_out = 12'd8;
`endif
    sel = 1;
    start_go(1, 1'b0);
    feed(8, 4'd15, 4'd15, 0, -1);
    tick();
    checks++; if (out_m !== exp_out) begin errors++; $display("FAIL ovf_out: got %0d, want %0d", out_m, exp_out); end
    checks++; if (ovf_m !== 1'b1 || done_m !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: ovf %b done %b, want 1 1", ovf_m, done_m);
    end
  endtask

  task automatic test_reset_mid_run();
    sel = 0;
    start_go(0, 1'b0);
    feed(3, 4'd2, 4'd2, 0, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_m !== 12'd0 || done_m !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out: out %0d done %b, want 0 0", out_m, done_m);
    end
    checks++; if (busy_m !== 1'b0 || rdy_m !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: busy %b ready %b, want 0 0", busy_m, rdy_m);
    end
    start_go(0, 1'b0);
    feed(8, 4'd1, 4'd1, 0, -1);
    tick();
    checks++; if (out_m !== 12'd8 || done_m !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rerun: out %0d done %b, want 8 1", out_m, done_m);
    end
  endtask

  task automatic test_back_to_back();
    sel = 2;
    start_go(2, 1'b0);
    feed(1, 4'd9, 4'd9, 0, -1);
    checks++; if (done_m !== 1'b0 || busy_m !== 1'b1) begin
      errors++; $display("FAIL one_drain: done %b busy %b, want 0 1", done_m, busy_m);
    end
    tick();
    checks++; if (out_m !== 12'd81 || done_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++; $display("FAIL one_out: out %0d done %b busy %b, want 81 1 0", out_m, done_m, busy_m);
    end
    start_go(2, 1'b0);
    checks++; if (busy_m !== 1'b1 || rdy_m !== 1'b1) begin
      errors++; $display("FAIL b2b_go: busy %b ready %b, want 1 1", busy_m, rdy_m);
    end
    feed(1, 4'd2, 4'd3, 0, -1);
    tick();
    checks++; if (out_m !== 12'd6 || done_m !== 1'b1) begin
      errors++; $display("FAIL b2b_out: out %0d done %b, want 6 1", out_m, done_m);
    end
  endtask

  initial begin
    rst = 1'b1; smode = 1'b0; vld = 1'b0; a = 4'd0; b = 4'd0;
    go0 = 1'b0; go8 = 1'b0; go1 = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_pressure();
    test_overflow();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
